// File: rtl/z80fi_collector_pkg.sv
// z80fi_collector_pkg: shared limits, FSM encoding and error-cause bit positions for the collector
package z80fi_collector_pkg;
  localparam int SLOTS = 2;
  localparam int MAX_LEN = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam int ERR_W = 4;
  localparam int ERR_LEN = 0;
  localparam int ERR_RD = 1;
  localparam int ERR_WR = 2;
  localparam int ERR_START = 3;
endpackage

// File: rtl/z80fi_mem_slot_capture.sv
// z80fi_mem_slot_capture: two-slot in-order capture of memory events; outputs include the current cycle's event
module z80fi_mem_slot_capture
  import z80fi_collector_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [15:0] addr1,
  output logic [15:0] addr2,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic        flag1,
  output logic        flag2,
  output logic        overflow
);
  logic [SLOTS-1:0] f_q;
  logic [15:0] a1_q, a2_q;
  logic [7:0] d1_q, d2_q;
  logic ov_q;
  always_comb begin
    flag1 = f_q[0] | valid;
    flag2 = f_q[1] | (valid & f_q[0]);
    addr1 = (valid & ~f_q[0]) ? addr : a1_q;
    data1 = (valid & ~f_q[0]) ? data : d1_q;
    addr2 = (valid & f_q[0] & ~f_q[1]) ? addr : a2_q;
    data2 = (valid & f_q[0] & ~f_q[1]) ? data : d2_q;
    overflow = ov_q | (valid & f_q[1]);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      f_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      ov_q <= 1'b0;
    end else begin
      f_q <= {flag2, flag1};
      a1_q <= addr1;
      a2_q <= addr2;
      d1_q <= data1;
      d2_q <= data2;
      ov_q <= overflow;
    end
  end
endmodule

// File: rtl/z80fi_collector.sv
// z80fi_collector: assembles per-cycle fetch/read/write events into one retirement record per instruction
module z80fi_collector
  import z80fi_collector_pkg::*;
#(
  parameter int REGS_W = 208
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              insn_start,
  input  logic              opcode_valid,
  input  logic [7:0]        opcode_byte,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_wr_valid,
  input  logic [15:0]       mem_wr_addr,
  input  logic [7:0]        mem_wr_data,
  input  logic              insn_done,
  input  logic [REGS_W-1:0] core_regs,
  output logic              z80fi_valid,
  output logic [31:0]       z80fi_insn,
  output logic [2:0]        z80fi_insn_len,
  output logic              z80fi_mem_rd,
  output logic              z80fi_mem_rd2,
  output logic              z80fi_mem_wr,
  output logic              z80fi_mem_wr2,
  output logic [15:0]       z80fi_mem_raddr,
  output logic [15:0]       z80fi_mem_raddr2,
  output logic [15:0]       z80fi_mem_waddr,
  output logic [15:0]       z80fi_mem_waddr2,
  output logic [7:0]        z80fi_mem_rdata,
  output logic [7:0]        z80fi_mem_rdata2,
  output logic [7:0]        z80fi_mem_wdata,
  output logic [7:0]        z80fi_mem_wdata2,
  output logic [REGS_W-1:0] z80fi_regs_in,
  output logic [REGS_W-1:0] z80fi_regs_out,
  output logic              z80fi_error
);
  logic [0:0] state;
  logic [31:0] insn_q, insn_n;
  logic [2:0] len_q, len_n;
  logic [ERR_W-1:0] err_q, cause;
  logic [REGS_W-1:0] regs_in_q;
  logic collecting, fetch, len_ov, emit;
  logic [15:0] ra1, ra2, wa1, wa2;
  logic [7:0] rd1, rd2, wd1, wd2;
  logic rf1, rf2, wf1, wf2, rd_ov, wr_ov;
  assign collecting = state == COLLECT;
  assign fetch = collecting & opcode_valid & ~insn_start;
  assign len_ov = fetch & (len_q == 3'(MAX_LEN));
  assign len_n = (fetch & ~len_ov) ? len_q + 3'd1 : len_q;
  assign emit = collecting & (insn_done | insn_start);
  z80fi_mem_slot_capture rd_cap (
    .clk(clk), .rst(reset), .clear(insn_start), .valid(collecting & mem_rd_valid),
    .addr(mem_rd_addr), .data(mem_rd_data), .addr1(ra1), .addr2(ra2),
    .data1(rd1), .data2(rd2), .flag1(rf1), .flag2(rf2), .overflow(rd_ov)
  );
  z80fi_mem_slot_capture wr_cap (
    .clk(clk), .rst(reset), .clear(insn_start), .valid(collecting & mem_wr_valid),
    .addr(mem_wr_addr), .data(mem_wr_data), .addr1(wa1), .addr2(wa2),
    .data1(wd1), .data2(wd2), .flag1(wf1), .flag2(wf2), .overflow(wr_ov)
  );
  always_comb begin
    insn_n = insn_q;
    if (fetch && !len_ov) insn_n[{len_q[1:0], 3'b000} +: 8] = opcode_byte;
  end
  always_comb begin
    cause = err_q;
    cause[ERR_LEN] = err_q[ERR_LEN] | len_ov;
    cause[ERR_RD] = err_q[ERR_RD] | rd_ov;
    cause[ERR_WR] = err_q[ERR_WR] | wr_ov;
    cause[ERR_START] = err_q[ERR_START] | (insn_start & ~insn_done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      insn_q <= '0;
      len_q <= '0;
      err_q <= '0;
      regs_in_q <= '0;
      z80fi_valid <= 1'b0;
      z80fi_insn <= '0;
      z80fi_insn_len <= '0;
      z80fi_mem_rd <= 1'b0;
      z80fi_mem_rd2 <= 1'b0;
      z80fi_mem_wr <= 1'b0;
      z80fi_mem_wr2 <= 1'b0;
      z80fi_mem_raddr <= '0;
      z80fi_mem_raddr2 <= '0;
      z80fi_mem_waddr <= '0;
      z80fi_mem_waddr2 <= '0;
      z80fi_mem_rdata <= '0;
      z80fi_mem_rdata2 <= '0;
      z80fi_mem_wdata <= '0;
      z80fi_mem_wdata2 <= '0;
      z80fi_regs_in <= '0;
      z80fi_regs_out <= '0;
      z80fi_error <= 1'b0;
    end else begin
      z80fi_valid <= emit;
      if (emit) begin
        z80fi_insn <= insn_n;
        z80fi_insn_len <= len_n;
        z80fi_mem_rd <= rf1;
        z80fi_mem_rd2 <= rf2;
        z80fi_mem_wr <= wf1;
        z80fi_mem_wr2 <= wf2;
        z80fi_mem_raddr <= ra1;
        z80fi_mem_raddr2 <= ra2;
        z80fi_mem_waddr <= wa1;
        z80fi_mem_waddr2 <= wa2;
        z80fi_mem_rdata <= rd1;
        z80fi_mem_rdata2 <= rd2;
        z80fi_mem_wdata <= wd1;
        z80fi_mem_wdata2 <= wd2;
        z80fi_regs_in <= regs_in_q;
        z80fi_regs_out <= core_regs;
        z80fi_error <= |cause;
      end
      // A new start always opens a fresh record, even when it also closes the previous one
      if (insn_start) begin
        state <= COLLECT;
        insn_q <= {24'h0, opcode_byte};
        len_q <= 3'd1;
        err_q <= '0;
        regs_in_q <= core_regs;
      end else if (collecting && insn_done) begin
        state <= IDLE;
      end else if (collecting) begin
        insn_q <= insn_n;
        len_q <= len_n;
        err_q[ERR_LEN] <= cause[ERR_LEN];
      end
    end
  end
endmodule
